// File: rtl/serial_phase_loader.sv
// Deserialises a host bit stream into one ROWS x COLS frame of PHASE_W-bit phase words.
// A frame is published on phi_out only when all NBITS bits have arrived; a restart mid-frame flags frame_err.
module serial_phase_loader #(
   parameter int ROWS    = 5,
   parameter int COLS    = 3,
   parameter int PHASE_W = 4,
   parameter int NBITS   = ROWS * COLS * PHASE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [0:NBITS-1] phi_out,
   output logic             phi_valid,
   output logic             busy,
   output logic             frame_err
);

   localparam int CW = $clog2(NBITS);
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [0:NBITS-1]  shadow_q;
   logic [0:NBITS-1]  phi_out_q;
   logic              phi_valid_q;
   logic              busy_q;
   logic              frame_err_q;

   // Valid/ready contract: there is no back-pressure. bit_in is consumed on every
   // cycle bit_valid=1 while busy; phi_valid and frame_err are single-cycle strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         phi_out_q   <= '0;
         phi_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         phi_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            LOAD: begin
               if (bit_valid && (cnt_q == LAST)) begin
                  // Completing bit: a simultaneous start opens the next frame without error.
                  phi_out_q   <= {shadow_q[0:NBITS-2], bit_in};
                  phi_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  if (!start) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (start) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= '0;
               end else if (bit_valid) begin
                  shadow_q[cnt_q] <= bit_in;
                  cnt_q           <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign phi_out   = phi_out_q;
   assign phi_valid = phi_valid_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_phase_loader.sv
// Scoreboard bench for serial_phase_loader: expected frames are queued as bits are driven
// and compared whenever phi_valid pulses.
module tb_serial_phase_loader;

   localparam int NBITS = 60;
   localparam int NW    = 15;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             bit_in;
   logic             bit_valid;
   logic [0:NBITS-1] phi_out;
   logic             phi_valid;
   logic             busy;
   logic             frame_err;

   logic [0:NBITS-1] exp_q[$];
   int               n_checks;
   int               n_pass;
   int               n_valid;
   int               n_err;

   serial_phase_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .phi_out   (phi_out),
      .phi_valid (phi_valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // scoreboard: pop on every phi_valid pulse
   always @(negedge clk) begin
      if (rst_n && (phi_valid || frame_err)) begin
         check("valid_err_exclusive", {63'd0, phi_valid & frame_err}, 64'd0);
      end
      if (rst_n && phi_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            logic [0:NBITS-1] e;
            e = exp_q.pop_front();
            check("frame_data", {4'd0, phi_out}, {4'd0, e});
         end
      end
      if (rst_n && frame_err) n_err++;
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start     = 1'b1;
      bit_valid = 1'b0;
      cyc();
      start     = 1'b0;
   endtask

   task automatic send_bits(input logic [0:NBITS-1] f, input int n, input bit stall,
                            input bit start_on_last);
      for (int i = 0; i < n; i++) begin
         if (stall && (i % 3 == 2)) begin
            bit_valid = 1'b0;
            cyc();
         end
         bit_valid = 1'b1;
         bit_in    = f[i];
         start     = start_on_last && (i == n - 1);
         cyc();
         bit_valid = 1'b0;
         start     = 1'b0;
      end
   endtask

   function automatic logic [0:NBITS-1] rand_frame();
      logic [0:NBITS-1] f;
      for (int i = 0; i < NBITS; i++) f[i] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   logic [0:NBITS-1] f_basic;
   logic [0:NBITS-1] f_exp;
   logic [0:NBITS-1] f_r;
   logic [3:0]       words[NW];
   int               v0;
   int               e0;

   initial begin
      n_checks = 0; n_pass = 0; n_valid = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;

      // 1. reset with inputs toggling
      for (int i = 0; i < 3; i++) begin
         start     = i[0];
         bit_valid = ~i[0];
         bit_in    = 1'b1;
         cyc();
         check("reset_busy", {63'd0, busy}, 64'd0);
      end
      start = 1'b0; bit_valid = 1'b0;
      check("reset_phi_out", {4'd0, phi_out}, 64'd0);
      check("reset_valid", {62'd0, phi_valid, frame_err}, 64'd0);
      rst_n = 1'b1;
      cyc();

      // bit_valid in IDLE is ignored
      send_bits({NBITS{1'b1}}, 5, 1'b0, 1'b0);
      check("idle_ignore_busy", {63'd0, busy}, 64'd0);

      // 2. basic frame: stream as run lengths, expectation from word table
      f_basic = '0;
      for (int i = 0; i < NBITS; i++)
         f_basic[i] = (i < 12) || (i >= 20 && i < 40) || (i >= 48);
      words = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
      for (int k = 0; k < NW; k++) f_exp[k*4 +: 4] = words[k];
      do_start();
      check("load_busy", {63'd0, busy}, 64'd1);
      exp_q.push_back(f_exp);
      v0 = n_valid;
      send_bits(f_basic, NBITS - 1, 1'b0, 1'b0);
      check("no_early_valid", 64'(n_valid - v0), 64'd0);
      bit_valid = 1'b1; bit_in = f_basic[NBITS-1];
      cyc();
      bit_valid = 1'b0;
      check("latency_valid", {63'd0, phi_valid}, 64'd1);
      check("busy_fall", {63'd0, busy}, 64'd0);
      check("word3_zero", {60'd0, phi_out[12 +: 4]}, 64'd0);
      cyc();
      check("valid_one_cycle", {63'd0, phi_valid}, 64'd0);

      // 3. same frame with stalls
      do_start();
      exp_q.push_back(f_exp);
      v0 = n_valid;
      send_bits(f_basic, NBITS - 1, 1'b1, 1'b0);
      check("stall_no_early", 64'(n_valid - v0), 64'd0);
      send_bits({NBITS{f_basic[NBITS-1]}}, 1, 1'b0, 1'b0);
      cyc();
      check("stall_valid_count", 64'(n_valid - v0), 64'd1);

      // 4. abort then full frame of ones
      e0 = n_err;
      f_r = rand_frame();
      do_start();
      send_bits(f_r, 25, 1'b0, 1'b0);
      do_start();
      check("abort_err_pulse", {63'd0, frame_err}, 64'd1);
      check("abort_keeps_phi", {4'd0, phi_out}, {4'd0, f_exp});
      check("abort_busy", {63'd0, busy}, 64'd1);
      exp_q.push_back({NBITS{1'b1}});
      send_bits({NBITS{1'b1}}, NBITS, 1'b0, 1'b0);
      cyc();
      check("abort_err_count", 64'(n_err - e0), 64'd1);
      check("abort_phi_ones", {4'd0, phi_out}, {4'd0, {NBITS{1'b1}}});

      // 5. back-to-back frames
      e0 = n_err; v0 = n_valid;
      f_r = rand_frame();
      do_start();
      exp_q.push_back(f_r);
      send_bits(f_r, NBITS, 1'b0, 1'b1);
      check("b2b_busy_held", {63'd0, busy}, 64'd1);
      exp_q.push_back('0);
      send_bits('0, NBITS, 1'b0, 1'b0);
      cyc();
      check("b2b_valid_count", 64'(n_valid - v0), 64'd2);
      check("b2b_no_err", 64'(n_err - e0), 64'd0);
      check("b2b_phi_zero", {4'd0, phi_out}, 64'd0);

      // put a nonzero frame on phi_out so the reset clear is visible
      exp_q.push_back(f_exp);
      do_start();
      send_bits(f_exp, NBITS, 1'b0, 1'b0);
      cyc();

      // 6. reset mid-frame
      f_r = rand_frame();
      do_start();
      send_bits(f_r, 30, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("midreset_phi", {4'd0, phi_out}, 64'd0);
      check("midreset_busy", {63'd0, busy}, 64'd0);
      for (int t = 0; t < 3; t++) begin
         f_r = rand_frame();
         do_start();
         exp_q.push_back(f_r);
         send_bits(f_r, NBITS, 1'($urandom_range(0, 1)), 1'b0);
         cyc();
         check("post_reset_phi", {4'd0, phi_out}, {4'd0, f_r});
      end

      repeat (4) cyc();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
